// File: rtl/core_pkg.sv
// core_pkg: shared types for the memory stage.
//   load_store_func_code : LSU access type (LB, LH, LW, LBU, LHU, SB, SH, SW)
//   mem_state_e          : memory-stage FSM states
//   mem_req_t            : data-bus request payload
// Helpers classify accesses, detect misalignment and force-align lane offsets.
package core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned BE_W   = XLEN / 8;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } load_store_func_code;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    function automatic logic is_store(input load_store_func_code op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Halfwords need an even offset, words need offset 0.
    function automatic logic is_misaligned(input load_store_func_code op, input logic [1:0] o);
        case (op)
            LH, LHU, SH: return o[0];
            LW, SW:      return (o != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Drop the offset bits a given access width cannot use.
    function automatic logic [1:0] force_align(input load_store_func_code op, input logic [1:0] o);
        case (op)
            LH, LHU, SH: return {o[1], 1'b0};
            LW, SW:      return 2'b00;
            default:     return o;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory bus between the memory stage and the memory.
//   master (memory stage): drives data_req_op, data_addr_op, data_we_op, data_be_op,
//                          data_wdata_op; receives data_gnt_ip, data_rvalid_ip, data_rdata_ip
//   slave  (memory)      : the mirror image
interface mem_stage_if import core_pkg::*; ();

    logic            data_req_op;
    logic [XLEN-1:0] data_addr_op;
    logic            data_we_op;
    logic [BE_W-1:0] data_be_op;
    logic [XLEN-1:0] data_wdata_op;
    logic            data_gnt_ip;
    logic            data_rvalid_ip;
    logic [XLEN-1:0] data_rdata_ip;

    modport master (
        output data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
        input  data_gnt_ip, data_rvalid_ip, data_rdata_ip
    );

    modport slave (
        input  data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
        output data_gnt_ip, data_rvalid_ip, data_rdata_ip
    );

endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load formatter.
//   lsu_operator : load type
//   offset       : byte lane offset (already force-aligned)
//   rdata        : raw word from memory
//   load_data_c  : lane-extracted, sign/zero-extended result
module lsu_load_align import core_pkg::*; (
    input  load_store_func_code lsu_operator,
    input  logic [1:0]          offset,
    input  logic [XLEN-1:0]     rdata,
    output logic [XLEN-1:0]     load_data_c
);

    logic [XLEN-1:0] shifted;

    // Bring the selected lane down to bit 0, then extend.
    always_comb begin
        shifted     = rdata >> {offset, 3'b000};
        load_data_c = rdata;
        case (lsu_operator)
            LB:      load_data_c = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            LBU:     load_data_c = {{(XLEN-8){1'b0}}, shifted[7:0]};
            LH:      load_data_c = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            LHU:     load_data_c = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with req/gnt/rvalid data-bus FSM and MEM-WB register.
//   clock, reset        : single clock, synchronous active-high reset
//   lsu_*_ip            : EX-MEM entry (enable, operator), alu_result_ip, mem_wdata_ip,
//                         wb_valid_ip, write_reg_addr_ip
//   bus                 : mem_stage_if master (request out, gnt/rvalid/rdata in)
//   stall_op            : combinational hold of upstream stages
//   wb_*_op, write_reg_addr_op, misalign_op : registered MEM-WB outputs
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of
// force-aligning them.
module mem_stage import core_pkg::*; (
    input  logic                clock,
    input  logic                reset,
    input  logic                lsu_enable_ip,
    input  load_store_func_code lsu_operator_ip,
    input  logic [XLEN-1:0]     alu_result_ip,
    input  logic [XLEN-1:0]     mem_wdata_ip,
    input  logic                wb_valid_ip,
    input  logic [REG_AW-1:0]   write_reg_addr_ip,
    mem_stage_if.master         bus,
    output logic                stall_op,
    output logic [XLEN-1:0]     wb_data_op,
    output logic                wb_valid_op,
    output logic [REG_AW-1:0]   write_reg_addr_op,
    output logic                misalign_op
);

    mem_state_e      state, state_next;
    logic            misaligned_c;
    logic            mem_go_c;
    logic            store_c;
    logic            rvalid_done_c;
    logic [1:0]      offset_c;
    mem_req_t        req_c;
    logic [XLEN-1:0] load_data_c;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned_c = lsu_enable_ip & is_misaligned(lsu_operator_ip, alu_result_ip[1:0]);
`else
    assign misaligned_c = 1'b0;
`endif

    assign mem_go_c      = lsu_enable_ip & ~misaligned_c;
    assign store_c       = is_store(lsu_operator_ip);
    assign offset_c      = force_align(lsu_operator_ip, alu_result_ip[1:0]);
    assign rvalid_done_c = (state == WAIT_RVALID) && bus.data_rvalid_ip;

    // Request payload; upstream is held by stall_op, so it stays stable while pending.
    always_comb begin
        req_c.addr  = {alu_result_ip[XLEN-1:2], 2'b00};
        req_c.we    = store_c;
        req_c.be    = 4'b1111;
        req_c.wdata = mem_wdata_ip;
        case (lsu_operator_ip)
            LB, LBU, SB: begin
                req_c.be    = 4'b0001 << offset_c;
                req_c.wdata = {4{mem_wdata_ip[7:0]}};
            end
            LH, LHU, SH: begin
                req_c.be    = offset_c[1] ? 4'b1100 : 4'b0011;
                req_c.wdata = {2{mem_wdata_ip[15:0]}};
            end
            default: begin
                req_c.be    = 4'b1111;
                req_c.wdata = mem_wdata_ip;
            end
        endcase
    end

    assign bus.data_addr_op  = req_c.addr;
    assign bus.data_we_op    = req_c.we;
    assign bus.data_be_op    = req_c.be;
    assign bus.data_wdata_op = req_c.wdata;

    lsu_load_align u_load_align (
        .lsu_operator (lsu_operator_ip),
        .offset       (offset_c),
        .rdata        (bus.data_rdata_ip),
        .load_data_c  (load_data_c)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state, request and stall; gnt/rvalid seen in IDLE are ignored.
    always_comb begin
        state_next       = state;
        bus.data_req_op  = 1'b0;
        stall_op         = 1'b0;
        case (state)
            IDLE: begin
                if (mem_go_c) begin
                    bus.data_req_op = 1'b1;
                    stall_op        = 1'b1;
                    state_next      = bus.data_gnt_ip ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                bus.data_req_op = 1'b1;
                stall_op        = 1'b1;
                if (bus.data_gnt_ip) begin
                    state_next = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                stall_op = ~bus.data_rvalid_ip;
                if (bus.data_rvalid_ip) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            bus.data_req_op = 1'b0;
            stall_op        = 1'b0;
        end
    end

    // MEM-WB register: bubble while stalled, otherwise trap / memory result / pass-through.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_data_op        <= '0;
            wb_valid_op       <= 1'b0;
            write_reg_addr_op <= '0;
            misalign_op       <= 1'b0;
        end else if (stall_op) begin
            wb_data_op        <= '0;
            wb_valid_op       <= 1'b0;
            write_reg_addr_op <= '0;
            misalign_op       <= 1'b0;
        end else if (rvalid_done_c) begin
            wb_data_op        <= store_c ? alu_result_ip : load_data_c;
            wb_valid_op       <= wb_valid_ip & ~store_c;
            write_reg_addr_op <= write_reg_addr_ip;
            misalign_op       <= 1'b0;
        end else if (misaligned_c) begin
            wb_data_op        <= alu_result_ip;
            wb_valid_op       <= 1'b0;
            write_reg_addr_op <= write_reg_addr_ip;
            misalign_op       <= 1'b1;
        end else begin
            wb_data_op        <= alu_result_ip;
            wb_valid_op       <= wb_valid_ip;
            write_reg_addr_op <= write_reg_addr_ip;
            misalign_op       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Honours MEM_MISALIGN_TRAP_EN for the misaligned-word scenario.
module tb_mem_stage;
    import core_pkg::*;

    logic                clock = 1'b0;
    logic                reset;
    logic                lsu_enable_ip;
    load_store_func_code lsu_operator_ip;
    logic [31:0]         alu_result_ip;
    logic [31:0]         mem_wdata_ip;
    logic                wb_valid_ip;
    logic [4:0]          write_reg_addr_ip;
    logic                stall_op;
    logic [31:0]         wb_data_op;
    logic                wb_valid_op;
    logic [4:0]          write_reg_addr_op;
    logic                misalign_op;

    int checks = 0;
    int errors = 0;

    mem_stage_if bus ();

    mem_stage dut (
        .clock             (clock),
        .reset             (reset),
        .lsu_enable_ip     (lsu_enable_ip),
        .lsu_operator_ip   (lsu_operator_ip),
        .alu_result_ip     (alu_result_ip),
        .mem_wdata_ip      (mem_wdata_ip),
        .wb_valid_ip       (wb_valid_ip),
        .write_reg_addr_ip (write_reg_addr_ip),
        .bus               (bus),
        .stall_op          (stall_op),
        .wb_data_op        (wb_data_op),
        .wb_valid_op       (wb_valid_op),
        .write_reg_addr_op (write_reg_addr_op),
        .misalign_op       (misalign_op)
    );

    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        lsu_enable_ip      = 1'b0;
        lsu_operator_ip    = LW;
        alu_result_ip      = '0;
        mem_wdata_ip       = '0;
        wb_valid_ip        = 1'b0;
        write_reg_addr_ip  = '0;
        bus.data_gnt_ip    = 1'b0;
        bus.data_rvalid_ip = 1'b0;
        bus.data_rdata_ip  = '0;
    endtask

    task automatic drive_entry(input load_store_func_code op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic wbv, input logic [4:0] rd);
        lsu_enable_ip     = 1'b1;
        lsu_operator_ip   = op;
        alu_result_ip     = addr;
        mem_wdata_ip      = wdata;
        wb_valid_ip       = wbv;
        write_reg_addr_ip = rd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        checks++; if (wb_data_op !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 00000000", wb_data_op); end
        checks++; if (wb_valid_op !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid_op); end
        checks++; if (write_reg_addr_op !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", write_reg_addr_op); end
        checks++; if (misalign_op !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_op); end
        checks++; if (bus.data_req_op !== 1'b0 || stall_op !== 1'b0) begin errors++; $display("FAIL reset_req_stall: got req=%b stall=%b expected 0 0", bus.data_req_op, stall_op); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        drive_entry(LW, 32'h100, 32'h0, 1'b1, 5'd5);
        bus.data_gnt_ip = 1'b1;
        #1;
        checks++; if (bus.data_req_op !== 1'b1 || stall_op !== 1'b1) begin errors++; $display("FAIL lw_req_stall: got req=%b stall=%b expected 1 1", bus.data_req_op, stall_op); end
        checks++; if (bus.data_addr_op !== 32'h100 || bus.data_we_op !== 1'b0 || bus.data_be_op !== 4'b1111) begin errors++; $display("FAIL lw_bus: got addr=%h we=%b be=%b expected 00000100 0 1111", bus.data_addr_op, bus.data_we_op, bus.data_be_op); end
        tick();
        checks++; if (wb_valid_op !== 1'b0 || write_reg_addr_op !== 5'd0) begin errors++; $display("FAIL lw_bubble: got valid=%b rd=%0d expected 0 0", wb_valid_op, write_reg_addr_op); end
        bus.data_gnt_ip    = 1'b0;
        bus.data_rvalid_ip = 1'b1;
        bus.data_rdata_ip  = 32'hDEADBEEF;
        #1;
        checks++; if (bus.data_req_op !== 1'b0 || stall_op !== 1'b0) begin errors++; $display("FAIL lw_rvalid_cycle: got req=%b stall=%b expected 0 0", bus.data_req_op, stall_op); end
        tick();
        checks++; if (wb_data_op !== 32'hDEADBEEF || wb_valid_op !== 1'b1 || write_reg_addr_op !== 5'd5) begin errors++; $display("FAIL lw_result: got data=%h valid=%b rd=%0d expected deadbeef 1 5", wb_data_op, wb_valid_op, write_reg_addr_op); end
        clear_inputs();
    endtask

    task automatic test_load_format();
        load_store_func_code ops [4] = '{LB, LBU, LH, LHU};
        logic [31:0] addrs [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] exp_d [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00002233};
        logic [3:0]  exp_be[4] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
        for (int i = 0; i < 4; i++) begin
            drive_entry(ops[i], addrs[i], 32'h0, 1'b1, 5'd10);
            bus.data_gnt_ip = 1'b1;
            #1;
            checks++; if (bus.data_be_op !== exp_be[i]) begin errors++; $display("FAIL load_be[%0d]: got %b expected %b", i, bus.data_be_op, exp_be[i]); end
            tick();
            bus.data_gnt_ip    = 1'b0;
            bus.data_rvalid_ip = 1'b1;
            bus.data_rdata_ip  = 32'h80112233;
            tick();
            checks++; if (wb_data_op !== exp_d[i] || wb_valid_op !== 1'b1) begin errors++; $display("FAIL load_data[%0d]: got %h valid=%b expected %h 1", i, wb_data_op, wb_valid_op, exp_d[i]); end
            clear_inputs();
        end
    endtask

    task automatic test_store_hold();
        drive_entry(SH, 32'h102, 32'h0000ABCD, 1'b1, 5'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.data_req_op !== 1'b1 || stall_op !== 1'b1 || bus.data_addr_op !== 32'h100) begin errors++; $display("FAIL sh_hold[%0d]: got req=%b stall=%b addr=%h expected 1 1 00000100", i, bus.data_req_op, stall_op, bus.data_addr_op); end
            checks++; if (bus.data_be_op !== 4'b1100 || bus.data_wdata_op[31:16] !== 16'hABCD || bus.data_we_op !== 1'b1) begin errors++; $display("FAIL sh_lane[%0d]: got be=%b wdata=%h we=%b expected 1100 abcd.... 1", i, bus.data_be_op, bus.data_wdata_op, bus.data_we_op); end
            tick();
        end
        bus.data_gnt_ip = 1'b1;
        #1;
        checks++; if (bus.data_req_op !== 1'b1) begin errors++; $display("FAIL sh_gnt_req: got %b expected 1", bus.data_req_op); end
        tick();
        bus.data_gnt_ip = 1'b0;
        #1;
        checks++; if (bus.data_req_op !== 1'b0 || stall_op !== 1'b1) begin errors++; $display("FAIL sh_wait_rvalid: got req=%b stall=%b expected 0 1", bus.data_req_op, stall_op); end
        tick();
        bus.data_rvalid_ip = 1'b1;
        tick();
        checks++; if (wb_valid_op !== 1'b0) begin errors++; $display("FAIL sh_wb_valid: got %b expected 0", wb_valid_op); end
        clear_inputs();
    endtask

    task automatic test_store_lanes();
        load_store_func_code ops [2] = '{SB, SW};
        logic [31:0] addrs [2] = '{32'h101, 32'h104};
        logic [31:0] wd    [2] = '{32'h0000005A, 32'h12345678};
        logic [31:0] exp_w [2] = '{32'h5A5A5A5A, 32'h12345678};
        logic [3:0]  exp_be[2] = '{4'b0010, 4'b1111};
        for (int i = 0; i < 2; i++) begin
            drive_entry(ops[i], addrs[i], wd[i], 1'b1, 5'd3);
            bus.data_gnt_ip = 1'b1;
            #1;
            checks++; if (bus.data_be_op !== exp_be[i] || bus.data_wdata_op !== exp_w[i]) begin errors++; $display("FAIL store_lane[%0d]: got be=%b wdata=%h expected %b %h", i, bus.data_be_op, bus.data_wdata_op, exp_be[i], exp_w[i]); end
            tick();
            bus.data_gnt_ip    = 1'b0;
            bus.data_rvalid_ip = 1'b1;
            tick();
            clear_inputs();
        end
    endtask

    task automatic test_nonmem();
        alu_result_ip      = 32'h12345678;
        wb_valid_ip        = 1'b1;
        write_reg_addr_ip  = 5'd7;
        bus.data_gnt_ip    = 1'b1;
        bus.data_rvalid_ip = 1'b1;
        #1;
        checks++; if (bus.data_req_op !== 1'b0 || stall_op !== 1'b0) begin errors++; $display("FAIL nonmem_req_stall: got req=%b stall=%b expected 0 0", bus.data_req_op, stall_op); end
        tick();
        checks++; if (wb_data_op !== 32'h12345678 || wb_valid_op !== 1'b1 || write_reg_addr_op !== 5'd7) begin errors++; $display("FAIL nonmem_pass: got data=%h valid=%b rd=%0d expected 12345678 1 7", wb_data_op, wb_valid_op, write_reg_addr_op); end
        bus.data_gnt_ip    = 1'b0;
        bus.data_rvalid_ip = 1'b0;
        alu_result_ip      = 32'h0000AA55;
        wb_valid_ip        = 1'b0;
        write_reg_addr_ip  = 5'd3;
        tick();
        checks++; if (wb_data_op !== 32'h0000AA55 || wb_valid_op !== 1'b0 || write_reg_addr_op !== 5'd3) begin errors++; $display("FAIL nonmem_b2b: got data=%h valid=%b rd=%0d expected 0000aa55 0 3", wb_data_op, wb_valid_op, write_reg_addr_op); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        drive_entry(LW, 32'h200, 32'h0, 1'b1, 5'd12);
        bus.data_gnt_ip = 1'b1;
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.data_rvalid_ip = 1'b1;
        bus.data_rdata_ip  = 32'hCAFEF00D;
        #1;
        checks++; if (bus.data_req_op !== 1'b0 || stall_op !== 1'b0) begin errors++; $display("FAIL rstmid_late_rvalid: got req=%b stall=%b expected 0 0", bus.data_req_op, stall_op); end
        tick();
        checks++; if (wb_data_op !== 32'h0 || wb_valid_op !== 1'b0 || write_reg_addr_op !== 5'd0) begin errors++; $display("FAIL rstmid_outputs: got data=%h valid=%b rd=%0d expected 00000000 0 0", wb_data_op, wb_valid_op, write_reg_addr_op); end
        clear_inputs();
        drive_entry(LW, 32'h300, 32'h0, 1'b1, 5'd13);
        #1;
        checks++; if (bus.data_req_op !== 1'b1) begin errors++; $display("FAIL rstmid_idle_req: got %b expected 1", bus.data_req_op); end
        bus.data_gnt_ip = 1'b1;
        tick();
        bus.data_gnt_ip    = 1'b0;
        bus.data_rvalid_ip = 1'b1;
        bus.data_rdata_ip  = 32'h0BADF00D;
        tick();
        checks++; if (wb_data_op !== 32'h0BADF00D || wb_valid_op !== 1'b1 || write_reg_addr_op !== 5'd13) begin errors++; $display("FAIL rstmid_next_lw: got data=%h valid=%b rd=%0d expected 0badf00d 1 13", wb_data_op, wb_valid_op, write_reg_addr_op); end
        clear_inputs();
    endtask

    task automatic test_misalign();
        drive_entry(LW, 32'h102, 32'h0, 1'b1, 5'd4);
        bus.data_gnt_ip = 1'b1;
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if (bus.data_req_op !== 1'b0 || stall_op !== 1'b0) begin errors++; $display("FAIL mis_trap_req: got req=%b stall=%b expected 0 0", bus.data_req_op, stall_op); end
        tick();
        checks++; if (misalign_op !== 1'b1 || wb_valid_op !== 1'b0) begin errors++; $display("FAIL mis_trap_flag: got misalign=%b valid=%b expected 1 0", misalign_op, wb_valid_op); end
        clear_inputs();
        tick();
        checks++; if (misalign_op !== 1'b0) begin errors++; $display("FAIL mis_trap_clear: got %b expected 0", misalign_op); end
`else
        checks++; if (bus.data_req_op !== 1'b1 || bus.data_addr_op !== 32'h100 || bus.data_be_op !== 4'b1111) begin errors++; $display("FAIL mis_align_req: got req=%b addr=%h be=%b expected 1 00000100 1111", bus.data_req_op, bus.data_addr_op, bus.data_be_op); end
        tick();
        bus.data_gnt_ip    = 1'b0;
        bus.data_rvalid_ip = 1'b1;
        bus.data_rdata_ip  = 32'h11223344;
        tick();
        checks++; if (wb_data_op !== 32'h11223344 || wb_valid_op !== 1'b1 || misalign_op !== 1'b0) begin errors++; $display("FAIL mis_align_result: got data=%h valid=%b misalign=%b expected 11223344 1 0", wb_data_op, wb_valid_op, misalign_op); end
`endif
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_format();
        test_store_hold();
        test_store_lanes();
        test_nonmem();
        test_reset_mid();
        test_misalign();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clock input 1: single clock; all state SHALL update on its rising edge.
REQ-002 reset input 1: synchronous, active-high reset.
REQ-003 lsu_enable_ip input 1: high SHALL mean the incoming EX-MEM entry is a load or store.
REQ-004 lsu_operator_ip input load_store_func_code: access type, one of LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-005 alu_result_ip input 32: byte address for memory ops; result data for non-memory ops.
REQ-006 mem_wdata_ip input 32: store data, right-justified.
REQ-007 wb_valid_ip input 1: the entry writes the regfile.
REQ-008 write_reg_addr_ip input 5: destination register.
REQ-009 data_req_op output 1: memory request.
REQ-010 data_gnt_ip input 1: memory accepted the request this cycle.
REQ-011 data_rvalid_ip input 1: response/completion this cycle, for loads and stores.
REQ-012 data_addr_op output 32: word-aligned address, alu_result_ip[31:2] concatenated with 2'b00.
REQ-013 data_we_op output 1: 1 for store, 0 for load.
REQ-014 data_be_op output 4: byte enables.
REQ-015 data_wdata_op output 32: store data shifted to the byte lane.
REQ-016 data_rdata_ip input 32: raw load word.
REQ-017 stall_op output 1: holds all upstream stages.
REQ-018 wb_data_op output 32: registered; formatted load data for loads, alu_result_ip otherwise.
REQ-019 wb_valid_op output 1: registered regfile write enable.
REQ-020 write_reg_addr_op output 5: registered destination register.
REQ-021 misalign_op output 1: registered misaligned-access flag.

Function
REQ-022 The FSM SHALL have three states: IDLE, WAIT_GNT, and WAIT_RVALID.
- In IDLE with lsu_enable_ip=1, data_req_op SHALL be asserted combinationally in the same cycle.
- On data_gnt_ip=1 the FSM SHALL go to WAIT_RVALID; otherwise it SHALL go to WAIT_GNT.
REQ-023 In WAIT_GNT, data_req_op SHALL remain 1 with address, we, be and wdata stable.
- On data_gnt_ip=1 the FSM SHALL go to WAIT_RVALID.
REQ-024 In WAIT_RVALID, data_req_op SHALL be 0.
- On data_rvalid_ip=1 the FSM SHALL return to IDLE.
- A grant and rvalid in the same cycle SHALL NOT occur.
REQ-025 stall_op SHALL be 1 whenever a memory op is in progress and data_rvalid_ip=0 this cycle.
- stall_op SHALL fall in the rvalid cycle.
- Minimum load/store latency SHALL be 2 cycles (req+gnt, then rvalid).
REQ-026 While stall_op=1, the MEM-WB register SHALL load a bubble: wb_valid_op=0, write_reg_addr_op=0.
REQ-027 In the rvalid cycle, the MEM-WB register SHALL capture the formatted result.
- Stores SHALL register wb_valid_op=0.
REQ-028 Non-memory entries SHALL pass to MEM-WB in 1 cycle without a request.
REQ-029 Byte enables and store data SHALL be formed from address bits [1:0] = o:
- SB: be = 1<<o, data replicated in the byte lane.
- SH: be = 0011 or 1100.
- SW: be = 1111.
REQ-030 Load formatting SHALL extract the lane selected by o.
- LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word through.
REQ-031 data_rvalid_ip or data_gnt_ip arriving in IDLE SHALL be ignored.

Reset
REQ-032 Reset SHALL force:
- FSM to IDLE.
- data_req_op=0 and stall_op=0 from the next cycle.
- wb_data_op=0, wb_valid_op=0, write_reg_addr_op=0, misalign_op=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction; its late rvalid SHALL be ignored per REQ-031.

Configuration
REQ-034 With MEM_MISALIGN_TRAP_EN defined, misaligned accesses SHALL issue no request and complete in 1 cycle:
- Misaligned means LH/LHU/SH with o[0]=1, or LW/SW with o!=0.
- The result SHALL be registered with misalign_op=1 and wb_valid_op=0.
REQ-035 Without MEM_MISALIGN_TRAP_EN:
- Misaligned halfword accesses SHALL be force-aligned by clearing o[0].
- Misaligned word accesses SHALL be force-aligned by clearing o.
- misalign_op SHALL be tied to 0.

Structure
REQ-036 load_store_func_code and the FSM state enum SHALL live in CORE_PKG.
REQ-037 Load formatting SHALL be a combinational sub-module, lsu_load_align.

Verification
REQ-038 LW at 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF:
- stall_op=1 for 1 cycle.
- wb_data_op=0xDEADBEEF and wb_valid_op=1 after the rvalid edge.
REQ-039 LB at 0x103 with rdata 0x80112233 -> wb_data_op=0xFFFFFF80.
- LBU at the same address -> wb_data_op=0x00000080.
REQ-040 SH at 0x102 with wdata 0x0000ABCD:
- data_be_op=1100 and data_wdata_op[31:16]=0xABCD.
- gnt withheld 3 cycles -> req held 3 cycles with stable address.
REQ-041 Reset asserted in WAIT_RVALID, then rvalid 1 cycle later -> outputs stay at reset values and the FSM stays in IDLE.
REQ-042 LW at 0x102:
- Macro on -> no req, misalign_op=1.
- Macro off -> data_addr_op=0x100, normal completion.
